dna_phy_reader: RTL and testbench
=================================

Name: dna_phy_reader

Overview:
Reads the 57-bit factory device DNA from the Xilinx DNA_PORT primitive over its serial interface and presents it as a parallel word with a valid flag. The primitive stays outside this block, and the block drives its CLK/READ/SHIFT/DIN pins. A read runs automatically after reset and can be re-run on request. The block sits at system level beside licensing and ID logic.

Parameters:
CLK_DIV, 4, sys_clk cycles per dna_clk period; even and >=2; dna_clk must stay <=100 MHz.
DNA_WIDTH, 57, number of DNA bits; fixed by the primitive.
EXPECTED_DNA, 57'h0, reference value for the optional match check.

Ports:
sys_clk  in  1  system clock; all logic on rising edge.
sys_rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; requests a re-read and is ignored while busy.
dna_clk  out  1  to DNA_PORT.CLK.
dna_read  out  1  to DNA_PORT.READ.
dna_shift  out  1  to DNA_PORT.SHIFT.
dna_din  out  1  to DNA_PORT.DIN; tied 0.
dna_dout  in  1  from DNA_PORT.DOUT.
dna_value  out  57  captured DNA, bit 56 first out of the port.
dna_valid  out  1  high while dna_value holds a complete read.
busy  out  1  high from read start to completion.

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Reset values: dna_clk=0, dna_read=0, dna_shift=0, dna_din=0, dna_value=0, dna_valid=0, busy=0, divider=0, bit counter=0, state=IDLE. An auto-start request is latched pending.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
  - Rise event: div_cnt wraps to 0; dna_clk goes 1 on that edge.
  - Fall event: div_cnt reaches CLK_DIV/2; dna_clk goes 0 on that edge.
  - The divider runs continuously after reset.
- dna_read, dna_shift and the dna_dout capture change or occur only on fall events. This keeps control stable half a period around each dna_clk rising edge.
- States: IDLE, LOAD, SHIFT, DONE.
  - IDLE: on a fall event with a request pending (auto-start after reset, or a latched start), set dna_read=1, busy=1, clear dna_valid, go to LOAD.
  - LOAD: the next dna_clk rise loads the DNA register. On the following fall event, set dna_read=0, capture dna_dout as bit 56, set dna_shift=1, set bit counter=1, go to SHIFT.
  - SHIFT: each fall event captures dna_dout into the next lower bit (shift-left capture, MSB first) and increments the counter. When the 57th bit is captured, dna_shift=0 in the same edge and the state goes to DONE. dna_shift is asserted for exactly 56 dna_clk rising edges.
  - DONE: on the next sys_clk, dna_value is updated, dna_valid=1, busy=0, and the state returns to IDLE.
- dna_value changes only at completion, so intermediate shift data is never visible.
- start: a pulse in IDLE is latched and serviced at the next fall event. A pulse while busy=1 is dropped. A re-read keeps the old dna_value visible but drops dna_valid at LOAD entry.
- Reset mid-read: every output returns to its reset value on the next edge, and a fresh auto-read follows.
- Latency, reset release to dna_valid: at most (DNA_WIDTH+3)*CLK_DIV sys_clk cycles, i.e. <=240 for CLK_DIV=4.

Optional Feature:
DNA_MATCH_EN:
- Defined: add output dna_match (1 bit, reset 0). It is set in the DONE edge to (captured value == EXPECTED_DNA) and cleared when a new read starts.
- Undefined: the port and its compare logic are absent.

Test Plan:
- Reset then release, bench DNA_PORT model loaded with 57'h1A2B3C4D5E6F701, CLK_DIV=4 -> dna_valid=1 within 240 cycles and dna_value=57'h1A2B3C4D5E6F701.
- Protocol check: count dna_clk rising edges with dna_read=1 and with dna_shift=1 -> exactly 1 and 56. Neither control toggles within 1 sys_clk of a dna_clk rise. dna_din=0 throughout.
- Change the model value to 57'h0000000000000AA, pulse start after valid -> dna_valid drops at LOAD, busy=1, and the value stays 57'h1A2B3C4D5E6F701 until completion. It then becomes 57'h0000000000000AA.
- Pulse start while busy=1 -> ignored; exactly one read sequence runs.
- Assert sys_rst mid-SHIFT (after 20 bits) -> outputs at their reset values on the next edge; the auto-read completes with the correct value.
- DNA_MATCH_EN defined, EXPECTED_DNA=57'h1A2B3C4D5E6F701 -> dna_match=1. Model value 57'h1A2B3C4D5E6F700 -> dna_match=0.

Source files
------------

// File: rtl/dna_phy_reader.sv
// dna_phy_reader
// Reads the 57-bit factory device DNA out of an external DNA_PORT primitive
// over its serial CLK/READ/SHIFT/DIN/DOUT interface and presents it as a
// parallel word with a valid flag. A read runs automatically after reset and
// can be re-run with a start pulse.
//
// Optional feature macro: DNA_MATCH_EN adds output dna_match, which reports
// whether the last completed read equals EXPECTED_DNA.
//
// Ports:
//   sys_clk    in   system clock, all logic on the rising edge
//   sys_rst    in   synchronous active-high reset
//   start      in   one-cycle re-read request, ignored while busy
//   dna_clk    out  DNA_PORT.CLK (sys_clk / CLK_DIV)
//   dna_read   out  DNA_PORT.READ
//   dna_shift  out  DNA_PORT.SHIFT
//   dna_din    out  DNA_PORT.DIN, tied 0
//   dna_dout   in   DNA_PORT.DOUT
//   dna_value  out  captured DNA, bit 56 is the first bit out of the port
//   dna_valid  out  high while dna_value holds a complete read
//   busy       out  high from read start to completion
//   dna_match  out  (DNA_MATCH_EN only) last read == EXPECTED_DNA
//   dbg_state  out  current FSM state (0 IDLE, 1 LOAD, 2 SHIFT, 3 DONE)
//
// Handshake: start is a single-cycle pulse, accepted only while busy is low;
// dna_value is meaningful only while dna_valid is high.
module dna_phy_reader #(
  parameter int                   CLK_DIV      = 4,
  parameter int                   DNA_WIDTH    = 57,
  parameter logic [DNA_WIDTH-1:0] EXPECTED_DNA = '0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start,
  output logic                 dna_clk,
  output logic                 dna_read,
  output logic                 dna_shift,
  output logic                 dna_din,
  input  logic                 dna_dout,
  output logic [DNA_WIDTH-1:0] dna_value,
  output logic                 dna_valid,
  output logic                 busy,
`ifdef DNA_MATCH_EN
  output logic                 dna_match,
`endif
  output logic [1:0]           dbg_state
);

  localparam int CW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BCW = $clog2(DNA_WIDTH);
  localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  DIV_FALL  = CW'(CLK_DIV / 2 - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DNA_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  state_t                 r_state, w_state;
  logic [CW-1:0]          r_div, w_div;
  logic [BCW-1:0]         r_bcnt, w_bcnt;
  logic                   r_dclk, w_dclk;
  logic                   r_read, w_read;
  logic                   r_shift, w_shift;
  logic                   r_pend, w_pend;
  logic [DNA_WIDTH-1:0]   r_sreg, w_sreg;
  logic [DNA_WIDTH-1:0]   r_value, w_value;
  logic                   r_valid, w_valid;
  logic                   r_busy, w_busy;
  logic                   r_match, w_match;
  logic                   w_rise, w_fall;

  // Events are decoded one cycle early so dna_clk changes on the edge where
  // the divider wraps (rise) or reaches CLK_DIV/2 (fall).
  assign w_rise = (r_div == DIV_LAST);
  assign w_fall = (r_div == DIV_FALL);

  always_comb begin
    w_state = r_state;
    w_div   = w_rise ? '0 : r_div + 1'b1;
    w_dclk  = w_rise ? 1'b1 : (w_fall ? 1'b0 : r_dclk);
    w_bcnt  = r_bcnt;
    w_read  = r_read;
    w_shift = r_shift;
    w_pend  = r_pend | (start & ~r_busy);
    w_sreg  = r_sreg;
    w_value = r_value;
    w_valid = r_valid;
    w_busy  = r_busy;
    w_match = r_match;
    case (r_state)
      ST_IDLE: begin
        if (w_fall && r_pend) begin
          w_read  = 1'b1;
          w_busy  = 1'b1;
          w_valid = 1'b0;
          w_match = 1'b0;
          w_pend  = 1'b0;
          w_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The dna_clk rise between the two falls has loaded the primitive,
        // so DOUT now presents the MSB.
        if (w_fall) begin
          w_read  = 1'b0;
          w_sreg  = {{(DNA_WIDTH-1){1'b0}}, dna_dout};
          w_shift = 1'b1;
          w_bcnt  = BCW'(1);
          w_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          w_sreg = {r_sreg[DNA_WIDTH-2:0], dna_dout};
          w_bcnt = r_bcnt + 1'b1;
          if (r_bcnt == LAST_BIT) begin
            w_shift = 1'b0;
            w_state = ST_DONE;
          end
        end
      end
      default: begin
        w_value = r_sreg;
        w_valid = 1'b1;
        w_busy  = 1'b0;
        w_match = (r_sreg == EXPECTED_DNA);
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bcnt  <= '0;
      r_dclk  <= 1'b0;
      r_read  <= 1'b0;
      r_shift <= 1'b0;
      r_pend  <= 1'b1;  // auto-read after reset
      r_sreg  <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bcnt  <= w_bcnt;
      r_dclk  <= w_dclk;
      r_read  <= w_read;
      r_shift <= w_shift;
      r_pend  <= w_pend;
      r_sreg  <= w_sreg;
      r_value <= w_value;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_match <= w_match;
    end
  end

  assign dna_clk   = r_dclk;
  assign dna_read  = r_read;
  assign dna_shift = r_shift;
  assign dna_din   = 1'b0;
  assign dna_value = r_value;
  assign dna_valid = r_valid;
  assign busy      = r_busy;
  assign dbg_state = r_state;

`ifdef DNA_MATCH_EN
  assign dna_match = r_match;
`else
  logic w_unused_match;
  assign w_unused_match = r_match;
`endif

endmodule

// File: tb/tb_dna_phy_reader.sv
// Testbench for dna_phy_reader: behavioural DNA_PORT model, protocol monitor,
// table of DNA patterns read back via start, plus hand-written sequences for
// reset/auto-read, start-while-busy and reset in the middle of a shift.
module tb_dna_phy_reader;

  localparam logic [56:0] DNA_A = 57'h1A2B3C4D5E6F701;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic        dna_clk, dna_read, dna_shift, dna_din, dna_dout;
  logic [56:0] dna_value;
  logic        dna_valid, busy;
  logic [1:0]  dbg_state;
`ifdef DNA_MATCH_EN
  logic        dna_match;
`endif

  dna_phy_reader #(.CLK_DIV(4), .DNA_WIDTH(57), .EXPECTED_DNA(DNA_A)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .dna_clk   (dna_clk),
    .dna_read  (dna_read),
    .dna_shift (dna_shift),
    .dna_din   (dna_din),
    .dna_dout  (dna_dout),
    .dna_value (dna_value),
    .dna_valid (dna_valid),
    .busy      (busy),
`ifdef DNA_MATCH_EN
    .dna_match (dna_match),
`endif
    .dbg_state (dbg_state)
  );

  // clock
  always #5 sys_clk = ~sys_clk;

  // DNA_PORT model: READ loads, SHIFT moves toward DOUT with DIN entering at the LSB
  logic [56:0] model_dna = '0;
  logic [56:0] model_reg = '0;
  always @(posedge dna_clk) begin
    if (dna_read)       model_reg <= model_dna;
    else if (dna_shift) model_reg <= {model_reg[55:0], dna_din};
  end
  assign dna_dout = model_reg[56];

  // protocol monitor
  int read_rises = 0;
  int shift_rises = 0;
  int viol = 0;
  int since_rise = 100;
  int since_tog = 100;
  bit mon_en = 1'b0;
  logic p_clk = 1'b0, p_read = 1'b0, p_shift = 1'b0;

  always @(posedge dna_clk) begin
    if (dna_read)  read_rises++;
    if (dna_shift) shift_rises++;
  end

  always @(negedge sys_clk) begin : mon
    bit rise, tog;
    rise = !p_clk && dna_clk;
    tog  = (dna_read !== p_read) || (dna_shift !== p_shift);
    if (rise) since_rise = 0; else if (since_rise < 1000) since_rise++;
    if (tog)  since_tog  = 0; else if (since_tog < 1000)  since_tog++;
    if (mon_en) begin
      if (tog && since_rise < 2) viol++;
      if (rise && since_tog < 2) viol++;
      if (dna_din !== 1'b0) viol++;
    end
    p_clk = dna_clk; p_read = dna_read; p_shift = dna_shift;
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [56:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    while (!busy && n < budget) begin tick(); n++; end
    chk({name, "_busy_seen"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_valid(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!dna_valid && cycles < budget) begin tick(); cycles++; end
    chk({name, "_valid_seen"}, 64'(dna_valid), 64'd1);
  endtask

  task automatic clear_mon();
    read_rises = 0; shift_rises = 0; viol = 0;
    since_rise = 100; since_tog = 100;
    mon_en = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_dna_clk"},   64'(dna_clk),   64'd0);
    chk({name, "_dna_read"},  64'(dna_read),  64'd0);
    chk({name, "_dna_shift"}, 64'(dna_shift), 64'd0);
    chk({name, "_dna_din"},   64'(dna_din),   64'd0);
    chk({name, "_dna_value"}, 64'(dna_value), 64'd0);
    chk({name, "_dna_valid"}, 64'(dna_valid), 64'd0);
    chk({name, "_busy"},      64'(busy),      64'd0);
    chk({name, "_state"},     64'(dbg_state), 64'd0);
`ifdef DNA_MATCH_EN
    chk({name, "_match"},     64'(dna_match), 64'd0);
`endif
  endtask

  task automatic check_read_protocol(input string name);
    chk({name, "_read_rises"},  64'(read_rises),  64'd1);
    chk({name, "_shift_rises"}, 64'(shift_rises), 64'd56);
    chk({name, "_proto_viol"},  64'(viol),        64'd0);
  endtask

  typedef struct {
    logic [56:0] dna;
    logic [56:0] exp_val;
    logic        exp_match;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int cyc;
    int busy_seen;
    logic [56:0] old_val;
    logic [56:0] exp_v;

    vecs[0] = '{57'h0000000000000AA, 57'h0000000000000AA, 1'b0};
    vecs[1] = '{57'h1FFFFFFFFFFFFFF, 57'h1FFFFFFFFFFFFFF, 1'b0};
    vecs[2] = '{57'h100000000000000, 57'h100000000000000, 1'b0};
    vecs[3] = '{57'h000000000000001, 57'h000000000000001, 1'b0};
    vecs[4] = '{57'h1A2B3C4D5E6F700, 57'h1A2B3C4D5E6F700, 1'b0};
    vecs[5] = '{57'h1A2B3C4D5E6F701, 57'h1A2B3C4D5E6F701, 1'b1};

    // reset and auto-read
    model_dna = DNA_A;
    sys_rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    clear_mon();
    sys_rst = 1'b0;
    wait_valid("auto", 300, cyc);
    chk("auto_latency_le_240", 64'(cyc <= 240), 64'd1);
    chk("auto_value", 64'(dna_value), 64'(DNA_A));
    chk("auto_busy_low", 64'(busy), 64'd0);
    check_read_protocol("auto");
`ifdef DNA_MATCH_EN
    chk("auto_match", 64'(dna_match), 64'd1);
`endif
    old_val = DNA_A;

    // table-driven re-reads
    for (int i = 0; i < 6; i++) begin
      repeat (3) tick();
      model_dna = vecs[i].dna;
      exp_q.push_back(vecs[i].exp_val);
      clear_mon();
      pulse_start();
      wait_busy($sformatf("vec%0d", i), 20);
      chk($sformatf("vec%0d_valid_dropped", i), 64'(dna_valid), 64'd0);
      chk($sformatf("vec%0d_old_value_kept", i), 64'(dna_value), 64'(old_val));
      repeat (100) tick();
      chk($sformatf("vec%0d_mid_value_kept", i), 64'(dna_value), 64'(old_val));
      wait_valid($sformatf("vec%0d", i), 300, cyc);
      exp_v = exp_q.pop_front();
      chk($sformatf("vec%0d_value", i), 64'(dna_value), 64'(exp_v));
      check_read_protocol($sformatf("vec%0d", i));
`ifdef DNA_MATCH_EN
      chk($sformatf("vec%0d_match", i), 64'(dna_match), 64'(vecs[i].exp_match));
`endif
      old_val = exp_v;
    end

    // start while busy is dropped
    repeat (3) tick();
    model_dna = 57'h0000000000000AA;
    clear_mon();
    pulse_start();
    wait_busy("busy_start", 20);
    repeat (60) tick();
    pulse_start();
    wait_valid("busy_start", 300, cyc);
    busy_seen = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (busy) busy_seen++;
    end
    chk("busy_start_no_second_read", 64'(busy_seen), 64'd0);
    chk("busy_start_value", 64'(dna_value), 64'h0AA);
    check_read_protocol("busy_start");

    // reset in the middle of the shift phase
    model_dna = 57'h0000000000000AA;
    clear_mon();
    pulse_start();
    cyc = 0;
    while (shift_rises < 20 && cyc < 200) begin tick(); cyc++; end
    chk("midrst_reached_20_bits", 64'(shift_rises >= 20), 64'd1);
    mon_en = 1'b0;
    sys_rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    tick();
    model_dna = DNA_A;
    clear_mon();
    sys_rst = 1'b0;
    wait_valid("midrst_auto", 300, cyc);
    chk("midrst_latency_le_240", 64'(cyc <= 240), 64'd1);
    chk("midrst_value", 64'(dna_value), 64'(DNA_A));
    check_read_protocol("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
